// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Arbitrates the single register-file write port between the ALU
//            and memory-load writeback paths, with an ALU anti-starvation mode.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              mem_valid,
   input  logic [ADDR_W-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   output logic              mem_ready,
   output logic [ADDR_W-1:0] rd,
   output logic              enable,
   output logic [DATA_W-1:0] DataWrite,
   output logic              grant_src,
   output logic [3:0]        starve_cnt
);

   typedef enum logic [0:0] {
      S_NORMAL = 1'b0,
      S_FAIR   = 1'b1
   } state_t;

   localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);
   localparam logic [3:0] c_STARVE_MAX   = 4'hF;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [3:0]          r_starve_cnt;
   logic [3:0]          w_starve_nxt;

   logic                w_alu_ready;
   logic                w_mem_ready;
   logic                w_alu_grant;
   logic                w_mem_grant;
   logic                w_any_grant;
   logic [ADDR_W-1:0]   w_sel_rd;
   logic [DATA_W-1:0]   w_sel_data;

   logic [ADDR_W-1:0]   r_rd;
   logic                r_enable;
   logic [DATA_W-1:0]   r_data;
   logic                r_grant_src;

   // Readies depend only on valids and state so a source's data never
   // feeds back into its own handshake.
   always_comb begin
      w_alu_ready = 1'b0;
      w_mem_ready = 1'b0;
      if (rst_n) begin
         case (r_state)
            S_FAIR: begin
               w_alu_ready = alu_valid;
               w_mem_ready = mem_valid & ~alu_valid;
            end
            default: begin
               w_mem_ready = mem_valid;
               w_alu_ready = alu_valid & ~mem_valid;
            end
         endcase
      end
   end

   assign w_alu_grant = alu_valid & w_alu_ready;
   assign w_mem_grant = mem_valid & w_mem_ready;
   assign w_any_grant = w_alu_grant | w_mem_grant;
   assign w_sel_rd    = w_mem_grant ? mem_rd   : alu_rd;
   assign w_sel_data  = w_mem_grant ? mem_data : alu_data;

   always_comb begin
      w_starve_nxt = r_starve_cnt;
      w_state_nxt  = r_state;

      if (w_alu_grant || !alu_valid) begin
         w_starve_nxt = 4'd0;
      end else if (w_mem_grant) begin
         w_starve_nxt = (r_starve_cnt == c_STARVE_MAX) ? c_STARVE_MAX
                                                       : r_starve_cnt + 4'd1;
      end

      case (r_state)
         S_NORMAL: begin
            if (w_starve_nxt >= c_STARVE_LIMIT) begin
               w_state_nxt = S_FAIR;
            end
         end
         S_FAIR: begin
            if (w_alu_grant || !alu_valid) begin
               w_state_nxt = S_NORMAL;
            end
         end
         default: w_state_nxt = S_NORMAL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_NORMAL;
         r_starve_cnt <= 4'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_starve_cnt <= w_starve_nxt;
      end
   end

   // Writes to x0 still occupy the port but never assert the enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd        <= '0;
         r_enable    <= 1'b0;
         r_data      <= '0;
         r_grant_src <= 1'b0;
      end else if (w_any_grant) begin
         r_rd        <= w_sel_rd;
         r_enable    <= (w_sel_rd != '0);
         r_data      <= w_sel_data;
         r_grant_src <= w_mem_grant;
      end else begin
         r_enable    <= 1'b0;
      end
   end

   assign alu_ready  = w_alu_ready;
   assign mem_ready  = w_mem_ready;
   assign rd         = r_rd;
   assign enable     = r_enable;
   assign DataWrite  = r_data;
   assign grant_src  = r_grant_src;
   assign starve_cnt = r_starve_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Directed, self-checking bench for regfile_write_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

   localparam int DATA_W       = 32;
   localparam int ADDR_W       = 5;
   localparam int STARVE_LIMIT = 4;

   logic              clk       = 1'b0;
   logic              rst_n     = 1'b1;
   logic              alu_valid = 1'b0;
   logic [ADDR_W-1:0] alu_rd    = '0;
   logic [DATA_W-1:0] alu_data  = '0;
   logic              alu_ready;
   logic              mem_valid = 1'b0;
   logic [ADDR_W-1:0] mem_rd    = '0;
   logic [DATA_W-1:0] mem_data  = '0;
   logic              mem_ready;
   logic [ADDR_W-1:0] rd;
   logic              enable;
   logic [DATA_W-1:0] DataWrite;
   logic              grant_src;
   logic [3:0]        starve_cnt;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   regfile_write_arbiter #(
      .DATA_W      (DATA_W),
      .ADDR_W      (ADDR_W),
      .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .alu_ready (alu_ready),
      .mem_valid (mem_valid),
      .mem_rd    (mem_rd),
      .mem_data  (mem_data),
      .mem_ready (mem_ready),
      .rd        (rd),
      .enable    (enable),
      .DataWrite (DataWrite),
      .grant_src (grant_src),
      .starve_cnt(starve_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: who may write this cycle, and what the port shows.
   bit          m_fair = 1'b0;
   int          m_cnt  = 0;
   logic [4:0]  m_rd   = '0;
   logic [31:0] m_data = '0;
   bit          m_en   = 1'b0;
   bit          m_src  = 1'b0;
   bit          m_ag, m_mg;
   bit          c_ar, c_mr;

   function automatic void model_ready(output bit ar, output bit mr);
      ar = 1'b0;
      mr = 1'b0;
      if (rst_n) begin
         if (alu_valid && mem_valid) begin
            if (m_fair) ar = 1'b1;
            else        mr = 1'b1;
         end else begin
            ar = alu_valid;
            mr = mem_valid;
         end
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_fair = 1'b0; m_cnt = 0; m_rd = '0; m_data = '0; m_en = 1'b0; m_src = 1'b0;
      end else begin
         bit was_fair;
         model_ready(m_ag, m_mg);
         m_ag = m_ag && alu_valid;
         m_mg = m_mg && mem_valid;
         if (m_ag || m_mg) begin
            m_rd   = m_mg ? mem_rd : alu_rd;
            m_data = m_mg ? mem_data : alu_data;
            m_src  = m_mg;
            m_en   = (m_rd != 0);
         end else begin
            m_en = 1'b0;
         end
         if (m_mg && alu_valid)         m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
         else if (m_ag || !alu_valid)   m_cnt = 0;
         was_fair = m_fair;
         if (!was_fair && m_cnt >= STARVE_LIMIT)     m_fair = 1'b1;
         else if (was_fair && (m_ag || !alu_valid))  m_fair = 1'b0;
      end
   end

   // Register file as seen from the DUT's write port.
   logic [31:0] dut_rf [32];

   always @(negedge clk) begin
      if (cmp_en) begin
         model_ready(c_ar, c_mr);
         chk("alu_ready",  alu_ready,  c_ar);
         chk("mem_ready",  mem_ready,  c_mr);
         chk("enable",     enable,     m_en);
         chk("rd",         rd,         m_rd);
         chk("DataWrite",  DataWrite,  m_data);
         chk("grant_src",  grant_src,  m_src);
         chk("starve_cnt", starve_cnt, m_cnt[3:0]);
         if (enable) dut_rf[rd] = DataWrite;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   string exp_order = "MMMMAMMMMA";
   int    exp_cnt [10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
   logic [7:0] letter;
   int mem_n, alu_n;

   initial begin
      for (int i = 0; i < 32; i++) dut_rf[i] = '0;
      #1;
      rst_n = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
      mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
      cmp_en = 1'b1;

      // Reset with both valids high
      tick(); tick();
      chk("rst_alu_ready", alu_ready, 0);
      chk("rst_mem_ready", mem_ready, 0);
      chk("rst_enable",    enable,    0);
      chk("rst_rd",        rd,        0);
      chk("rst_data",      DataWrite, 0);
      chk("rst_src",       grant_src, 0);
      rst_n = 1'b1;
      #1 chk("post_rst_mem_ready", mem_ready, 1);
      tick();
      mem_valid = 1'b0;
      chk("first_rd",  rd,        9);
      chk("first_en",  enable,    1);
      chk("first_src", grant_src, 1);
      chk("first_cnt", starve_cnt, 1);
      tick();
      alu_valid = 1'b0;
      chk("held_alu_rd",  rd,         3);
      chk("held_alu_src", grant_src,  0);
      chk("held_alu_cnt", starve_cnt, 0);
      tick();

      // ALU only
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hDEADBEEF;
      #1 chk("alu_only_ready", alu_ready, 1);
      tick();
      alu_valid = 1'b0;
      chk("alu_only_rd",   rd,        7);
      chk("alu_only_data", DataWrite, 32'hDEADBEEF);
      chk("alu_only_en",   enable,    1);
      chk("alu_only_src",  grant_src, 0);
      tick();
      chk("idle_en",   enable,    0);
      chk("idle_rd",   rd,        7);
      chk("idle_data", DataWrite, 32'hDEADBEEF);

      // Starvation: ALU held, ten loads streaming
      mem_n = 0; alu_n = 0;
      alu_valid = 1'b1; alu_rd = 5'd16; alu_data = 32'hA000_0000;
      mem_valid = 1'b1; mem_rd = 5'd1;  mem_data = 32'hB000_0000;
      for (int g = 0; g < 12; g++) begin
         #1;
         letter = mem_ready ? "M" : (alu_ready ? "A" : "-");
         tick();
         if (letter == "M") begin
            mem_n++;
            if (mem_n == 10) mem_valid = 1'b0;
            else begin
               mem_rd   = 5'(1 + mem_n);
               mem_data = 32'hB000_0000 + 32'(mem_n);
            end
         end else if (letter == "A") begin
            alu_n++;
            alu_rd   = 5'(16 + alu_n);
            alu_data = 32'hA000_0000 + 32'(alu_n);
         end
         if (g < 10) begin
            chk("grant_order", letter, exp_order[g]);
            chk("starve_seq",  starve_cnt, exp_cnt[g]);
         end
      end
      chk("loads_done", mem_n, 10);
      tick();
      alu_valid = 1'b0;
      tick();

      // Load to x0
      mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h12345678;
      #1 chk("x0_ready", mem_ready, 1);
      tick();
      mem_valid = 1'b0;
      chk("x0_rd",   rd,        0);
      chk("x0_data", DataWrite, 32'h12345678);
      chk("x0_en",   enable,    0);
      chk("x0_src",  grant_src, 1);
      tick();

      // Same rd from both sources
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'd1;
      mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'd2;
      #1;
      chk("tie_mem_ready", mem_ready, 1);
      chk("tie_alu_ready", alu_ready, 0);
      tick();
      mem_valid = 1'b0;
      chk("tie_first_data", DataWrite, 2);
      chk("tie_first_rd",   rd,        5);
      tick();
      alu_valid = 1'b0;
      chk("tie_second_data", DataWrite, 1);
      chk("tie_second_src",  grant_src, 0);
      tick();
      chk("rf_x5_final", dut_rf[5], 1);

      // Reach FAIR, then reset mid-cycle while enable is high
      alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hA5;
      mem_valid = 1'b1; mem_rd = 5'd21; mem_data = 32'hC0;
      for (int g = 0; g < 4; g++) begin
         tick();
         if (g == 3) mem_valid = 1'b0;
         else begin
            mem_rd   = 5'(22 + g);
            mem_data = 32'hC1 + 32'(g);
         end
      end
      chk("pre_rst_cnt", starve_cnt, 4);
      chk("pre_rst_en",  enable,     1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_en",        enable,     0);
      chk("mid_rst_cnt",       starve_cnt, 0);
      chk("mid_rst_alu_ready", alu_ready,  0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("rel_alu_ready", alu_ready,  1);
      chk("rel_cnt",       starve_cnt, 0);
      tick();
      alu_valid = 1'b0;
      chk("rel_rd",   rd,        20);
      chk("rel_data", DataWrite, 32'hA5);
      chk("rel_en",   enable,    1);
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (rd, enable, DataWrite) between two writeback requesters: the ALU result path and the memory-load result path.
- Each requester uses a valid/ready handshake.
- The block registers the winning request and drives the register-file write port one cycle later.
- Loads have default priority. A starvation counter guarantees forward progress for the ALU path. Writes to x0 are accepted but suppressed.

Parameters:
- DATA_W, 32, width of write data
- ADDR_W, 5, width of register address
- STARVE_LIMIT, 4, consecutive mem grants tolerated while alu_valid is held; legal range 1..15

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- alu_valid  input  1  ALU writeback request
- alu_rd  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU result
- alu_ready  output  1  ALU request accepted this cycle
- mem_valid  input  1  load writeback request
- mem_rd  input  ADDR_W  load destination register
- mem_data  input  DATA_W  load data
- mem_ready  output  1  load request accepted this cycle
- rd  output  ADDR_W  register-file write address
- enable  output  1  register-file write enable
- DataWrite  output  DATA_W  register-file write data
- grant_src  output  1  source of the current write port contents (0=ALU, 1=MEM)
- starve_cnt  output  4  current starvation count, for debug/coverage

Behaviour:
- Reset: on rst_n low, asynchronously clear rd=0, enable=0, DataWrite=0, grant_src=0, starve_cnt=0, FSM=NORMAL.
  - alu_ready and mem_ready are forced 0 while rst_n is low.
- Handshake:
  - A transfer occurs on a rising edge where X_valid & X_ready.
  - X_ready is combinational from the valid inputs and FSM state only, never from X_data or X_rd.
  - At most one ready is high in any cycle.
  - A source must hold valid, rd and data stable until accepted. The arbiter may take no action on a deasserted valid.
- Latency: a request accepted at edge N appears on rd/DataWrite/enable from edge N through edge N+1. The register file samples it at edge N+1.
  - Back-to-back acceptance every cycle is supported; throughput is 1 write/cycle.
- Idle cycle (no transfer): enable=0. rd, DataWrite and grant_src hold their previous values.
- x0 rule: an accepted request with rd==0 loads rd/DataWrite/grant_src normally but sets enable=0.
  - It still counts as a grant for arbitration and the starvation counter.
- FSM state NORMAL:
  - mem_valid=1 -> mem_ready=1.
  - Otherwise alu_ready=alu_valid.
- FSM state FAIR:
  - alu_valid=1 -> alu_ready=1, mem_ready=0.
  - Otherwise mem_ready=mem_valid.
- Starvation counter, evaluated at each edge:
  - MEM granted while alu_valid=1 -> starve_cnt+1, saturating at 15.
  - ALU granted, or alu_valid=0 -> starve_cnt=0.
  - Otherwise hold.
- FSM transitions:
  - NORMAL->FAIR when the next starve_cnt value reaches STARVE_LIMIT.
  - FAIR->NORMAL on the edge after an ALU grant, with starve_cnt cleared.
  - FAIR->NORMAL also if alu_valid drops while in FAIR.
- Simultaneous valid:
  - In NORMAL, MEM wins.
  - In FAIR, ALU wins.
  - The loser's ready is 0 and its request remains pending.
- Same rd from both sources in consecutive cycles: both writes issue in grant order. The later write is the final register value. No merging or reordering.
- Reset mid-operation:
  - A request accepted on the edge before rst_n falls is lost if its enable cycle is cut by reset. enable goes 0 immediately.
  - Sources re-present after reset; no state survives.
- Widths: no arithmetic on data; DataWrite is a pass-through register. starve_cnt is 4 bits unsigned.

Test Plan:
- Reset with both valids high -> both readys 0 and outputs 0 during reset. First edge after release grants MEM; next cycle rd=mem_rd, enable=1, grant_src=1.
- ALU only, alu_rd=7, alu_data=0xDEADBEEF -> alu_ready=1. Next cycle rd=7, DataWrite=0xDEADBEEF, enable=1, grant_src=0; then enable=0 when idle.
- alu_valid held constantly, mem_valid stream of 10 loads, STARVE_LIMIT=4 -> grant order M,M,M,M,A,M,M,M,M,A. starve_cnt shows 1,2,3,4,0 and repeats.
- MEM write with mem_rd=0, data=0x12345678 -> mem_ready=1. Next cycle rd=0, DataWrite=0x12345678, enable=0.
- ALU rd=5 data=1 and MEM rd=5 data=2 both valid in NORMAL -> write rd=5 data=2, then rd=5 data=1 on consecutive cycles. The bench's register-file model ends with x5=1.
- Assert rst_n low asynchronously mid-cycle while enable=1 -> enable drops before the next clk edge. After release starve_cnt=0, FSM=NORMAL, and a held ALU request is accepted on the first edge.
